// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the burst SRAM: cycle-type codes and the
// control FSM state encoding.
package wb_pkg;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] WB_CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_BURST = 2'd3
  } wb_state_e;

  // Reserved / unsupported cycle types behave exactly like a classic cycle.
  function automatic logic [2:0] cti_norm(input logic [2:0] cti);
    return ((cti == WB_CTI_INCR) || (cti == WB_CTI_EOB)) ? cti : WB_CTI_CLASSIC;
  endfunction

endpackage

// File: rtl/wb_sram_bank.sv
// Single-port, byte-enabled synchronous RAM with one-cycle read latency.
// The read register only updates when re is high, so it holds the last word
// read; it clears on reset while the array itself is never reset.
module wb_sram_bank
  import wb_pkg::*;
#(
  parameter int adr_width = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [adr_width-1:0] adr,
  input  logic [3:0]           sel,
  input  logic [31:0]          wdat,
  output logic [31:0]          rdat
);

  logic [31:0] mem [2**adr_width];
  logic [31:0] rdat_q, rdat_d;

  // Byte-lane write into the array.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (sel[i]) mem[adr][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  // Read register next value: new word on a read, otherwise hold.
  always_comb begin
    rdat_d = rdat_q;
    if (re) rdat_d = mem[adr];
  end

  // Read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdat_q <= '0;
    else        rdat_q <= rdat_d;
  end

  assign rdat = rdat_q;

endmodule

// File: rtl/wb_burst_sram.sv
// Wishbone slave SRAM with programmable wait states and optional incrementing
// bursts. Define WB_BURST_SRAM_BURST_EN to build burst support; without it the
// cycle type is ignored and every beat is a classic cycle.
//
// Handshake: a beat transfers on any cycle where wb_cyc_i, wb_stb_i and
// wb_ack_o are all high. Ack comes from a registered flag gated by the live
// strobe, so withdrawing cyc/stb always suppresses ack and any write.
module wb_burst_sram
  import wb_pkg::*;
#(
  parameter int adr_width   = 11,
  parameter int wait_states = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic [2:0]  wb_cti_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [2:0] WS = 3'(wait_states);

  wb_state_e            state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [adr_width-1:0] adr_q, adr_d;
  logic                 ack_q, ack_d;
  logic                 req;
  logic [adr_width-1:0] req_adr;
  logic                 bank_we, bank_re;
  logic [adr_width-1:0] bank_adr;

`ifdef WB_BURST_SRAM_BURST_EN
  logic [2:0] cti_n;
  assign cti_n = cti_norm(wb_cti_i);
`else
  logic [2:0] unused_cti;
  assign unused_cti = cti_norm(wb_cti_i);
`endif

  // Address bits outside the word index are decoded by the interconnect.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};

  assign req      = wb_cyc_i & wb_stb_i;
  assign req_adr  = wb_adr_i[adr_width+1:2];
  assign wb_ack_o = ack_q & req;

  // Writes commit at the edge closing an acked beat, at the beat's address.
  // Reads are issued one edge early (at the address of the next acked beat)
  // so the word is in the read register during its ack cycle.
  assign ack_d    = (state_d == ST_ACK) || (state_d == ST_BURST);
  assign bank_we  = wb_ack_o & wb_we_i;
  assign bank_re  = ack_d & ~wb_we_i;
  assign bank_adr = bank_we ? adr_q : adr_d;

  // Next-state, wait counter and beat address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d   = WS;
          adr_d   = req_adr;
          state_d = (WS != 3'd0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (!req)                 state_d = ST_IDLE;
        else if (cnt_q <= 3'd1)   state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
`ifdef WB_BURST_SRAM_BURST_EN
        if (wb_ack_o && (cti_n == WB_CTI_INCR)) begin
          state_d = ST_BURST;
          adr_d   = adr_q + adr_width'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
`ifdef WB_BURST_SRAM_BURST_EN
        // Ack is already high here; a live strobe means this beat is taken.
        if (req && (cti_n == WB_CTI_INCR)) begin
          state_d = ST_BURST;
          adr_d   = adr_q + adr_width'(1);
        end
`endif
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      ack_q   <= ack_d;
    end
  end

  assign dbg_state_o = state_q;

  wb_sram_bank #(
    .adr_width (adr_width)
  ) u_bank (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .we    (bank_we),
    .re    (bank_re),
    .adr   (bank_adr),
    .sel   (wb_sel_i),
    .wdat  (wb_dat_i),
    .rdat  (wb_dat_o)
  );

endmodule

// File: tb/tb_wb_burst_sram.sv
// Bench for wb_burst_sram. Three instances share the bus except cyc:
//   0: adr_width=11, wait_states=1   1: adr_width=4, wait_states=0
//   2: adr_width=11, wait_states=3
// Expectations for the cti sequence follow WB_BURST_SRAM_BURST_EN.
module tb_wb_burst_sram;
  import wb_pkg::*;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       adr = '0, wdat = '0;
  logic [3:0]        sel = '0;
  logic [2:0]        cti = '0;
  logic              we = 1'b0, stb = 1'b0;
  logic [2:0]        cyc = '0;
  logic [2:0]        ack;
  logic [2:0][31:0]  rdat;
  logic [2:0][1:0]   st;

  int          total = 0;
  int          bad = 0;
  int          ws [3] = '{1, 0, 3};
  logic [31:0] last_rd [3] = '{32'h0, 32'h0, 32'h0};

  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [31:0] dat;
    logic [3:0]  s;
    logic [31:0] e;
  } vec_t;

  typedef struct {
    logic        req;
    logic [2:0]  cti;
    logic        ack;
    logic        chk;
    logic [31:0] dat;
  } beat_t;

  vec_t  tbl [20];
  beat_t bt [6];

  // Clock
  always #5 clk = ~clk;

  wb_burst_sram #(.adr_width(11), .wait_states(1)) u_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(rdat[0]), .wb_sel_i(sel), .wb_cti_i(cti), .wb_we_i(we),
    .wb_cyc_i(cyc[0]), .wb_stb_i(stb), .wb_ack_o(ack[0]), .dbg_state_o(st[0]));

  wb_burst_sram #(.adr_width(4), .wait_states(0)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(rdat[1]), .wb_sel_i(sel), .wb_cti_i(cti), .wb_we_i(we),
    .wb_cyc_i(cyc[1]), .wb_stb_i(stb), .wb_ack_o(ack[1]), .dbg_state_o(st[1]));

  wb_burst_sram #(.adr_width(11), .wait_states(3)) u_c (
    .sys_clk(clk), .sys_rst_n(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(rdat[2]), .wb_sel_i(sel), .wb_cti_i(cti), .wb_we_i(we),
    .wb_cyc_i(cyc[2]), .wb_stb_i(stb), .wb_ack_o(ack[2]), .dbg_state_o(st[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int d, logic w, logic [31:0] a, logic [31:0] dat,
                              logic [3:0] s, logic [31:0] e);
    vec_t v;
    v.d = d; v.w = w; v.a = a; v.dat = dat; v.s = s; v.e = e;
    return v;
  endfunction

  function automatic beat_t mb(logic req, logic [2:0] c, logic a, logic chk, logic [31:0] dat);
    beat_t b;
    b.req = req; b.cti = c; b.ack = a; b.chk = chk; b.dat = dat;
    return b;
  endfunction

  // One classic transfer with a bounded wait for ack; checks latency and the
  // read data (or, for writes, that wb_dat_o still holds the last read word).
  task automatic classic(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] dat, input logic [3:0] s,
                         input logic [31:0] exp_rd, input string name);
    int   n;
    logic got;
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb = 1'b1; we = w; adr = a; wdat = dat; sel = s; cti = WB_CTI_CLASSIC;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ack[d]) begin
        got = 1'b1;
        check({name, " data"}, rdat[d], w ? last_rd[d] : exp_rd);
      end
    end
    check({name, " latency"}, 32'(n), 32'(2 + ws[d]));
    if (!w) last_rd[d] = exp_rd;
    @(posedge clk); #1;
    cyc[d] = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(0, 1, 32'h0000_0040, 32'hDEADBEEF, 4'hF, 32'h0);
    tbl[1]  = mk(0, 0, 32'h0000_0040, 32'h0,        4'hF, 32'hDEADBEEF);
    tbl[2]  = mk(0, 1, 32'h0000_0040, 32'h11223344, 4'hF, 32'h0);
    tbl[3]  = mk(0, 1, 32'h0000_0040, 32'hAABBCCDD, 4'b0101, 32'h0);
    tbl[4]  = mk(0, 0, 32'h0000_0040, 32'h0,        4'hF, 32'h11BB33DD);
    tbl[5]  = mk(0, 1, 32'h0000_0044, 32'h01020304, 4'hF, 32'h0);
    tbl[6]  = mk(0, 1, 32'h0000_0044, 32'hA0B0C0D0, 4'b1000, 32'h0);
    tbl[7]  = mk(0, 0, 32'hFFFF_E044, 32'h0,        4'hF, 32'hA0020304);
    tbl[8]  = mk(0, 1, 32'h0000_1FFC, 32'h5A5A5A5A, 4'hF, 32'h0);
    tbl[9]  = mk(0, 1, 32'h0000_1FFC, 32'h000000C3, 4'b0010, 32'h0);
    tbl[10] = mk(0, 0, 32'h0000_1FFF, 32'h0,        4'hF, 32'h5A5A005A);
    tbl[11] = mk(0, 0, 32'h0000_0043, 32'h0,        4'hF, 32'h11BB33DD);
    tbl[12] = mk(1, 1, 32'h0000_003C, 32'h11111111, 4'hF, 32'h0);
    tbl[13] = mk(1, 1, 32'h0000_0000, 32'h22222222, 4'hF, 32'h0);
    tbl[14] = mk(1, 1, 32'h0000_0004, 32'h33333333, 4'hF, 32'h0);
    tbl[15] = mk(1, 1, 32'h0000_0008, 32'h44444444, 4'hF, 32'h0);
    tbl[16] = mk(1, 0, 32'h0000_007C, 32'h0,        4'hF, 32'h11111111);
    tbl[17] = mk(1, 0, 32'h0000_0040, 32'h0,        4'hF, 32'h22222222);
    tbl[18] = mk(2, 1, 32'h0000_0008, 32'h12345678, 4'hF, 32'h0);
    tbl[19] = mk(2, 0, 32'h0000_0008, 32'h0,        4'hF, 32'h12345678);

`ifdef WB_BURST_SRAM_BURST_EN
    bt[0] = mb(1, WB_CTI_INCR,    0, 1, 32'h22222222);
    bt[1] = mb(1, WB_CTI_INCR,    1, 1, 32'h11111111);
    bt[2] = mb(1, WB_CTI_INCR,    1, 1, 32'h22222222);
    bt[3] = mb(1, WB_CTI_INCR,    1, 1, 32'h33333333);
    bt[4] = mb(1, WB_CTI_EOB,     1, 1, 32'h44444444);
    bt[5] = mb(0, WB_CTI_CLASSIC, 0, 1, 32'h44444444);
`else
    bt[0] = mb(1, WB_CTI_INCR,    0, 1, 32'h22222222);
    bt[1] = mb(1, WB_CTI_INCR,    1, 1, 32'h11111111);
    bt[2] = mb(1, WB_CTI_INCR,    0, 1, 32'h11111111);
    bt[3] = mb(1, WB_CTI_INCR,    1, 1, 32'h11111111);
    bt[4] = mb(1, WB_CTI_EOB,     0, 1, 32'h11111111);
    bt[5] = mb(0, WB_CTI_CLASSIC, 0, 1, 32'h11111111);
`endif

    // Reset values
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset ack %0d", d),   {31'b0, ack[d]}, 32'h0);
      check($sformatf("reset dat %0d", d),   rdat[d],         32'h0);
      check($sformatf("reset state %0d", d), {30'b0, st[d]},  {30'b0, S_IDLE});
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table of classic transfers
    for (int i = 0; i < 20; i++) begin
      classic(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].dat, tbl[i].s, tbl[i].e,
              $sformatf("vec%0d", i));
    end

    // Strobe held after a classic ack: ack must drop for a cycle
    @(posedge clk); #1;
    cyc[0] = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h40; cti = WB_CTI_CLASSIC;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("held ack c%0d", c), {31'b0, ack[0]}, (c == 3) ? 32'h1 : 32'h0);
      if (c == 3) check("held data", rdat[0], 32'h11BB33DD);
    end
    @(posedge clk); #1;
    cyc[0] = 1'b0; stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("held state", {30'b0, st[0]}, {30'b0, S_IDLE});

    // Incrementing cti sequence from word 15 on the 4-bit instance
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      cyc[1] = bt[c].req; stb = bt[c].req; we = 1'b0; adr = 32'h3C; cti = bt[c].cti;
      @(negedge clk);
      check($sformatf("cti ack c%0d", c + 1), {31'b0, ack[1]}, {31'b0, bt[c].ack});
      if (bt[c].chk) check($sformatf("cti data c%0d", c + 1), rdat[1], bt[c].dat);
    end
    last_rd[1] = bt[5].dat;
    @(negedge clk);
    check("cti end state", {30'b0, st[1]}, {30'b0, S_IDLE});

    // Strobe withdrawn during wait states of a write
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      cyc[2] = (c <= 4); stb = (c <= 2); we = 1'b1; adr = 32'h8;
      wdat = 32'hFFFFFFFF; sel = 4'hF; cti = WB_CTI_CLASSIC;
      @(negedge clk);
      check($sformatf("drop ack c%0d", c), {31'b0, ack[2]}, 32'h0);
      if (c == 2) check("drop wait state", {30'b0, st[2]}, {30'b0, S_WAIT});
      if (c == 4) check("drop idle state", {30'b0, st[2]}, {30'b0, S_IDLE});
    end
    we = 1'b0;
    classic(2, 0, 32'h8, 32'h0, 4'hF, 32'h12345678, "drop readback");

    // Reset during an acked read on the burst-capable instance
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3C; cti = WB_CTI_INCR;
    @(negedge clk);
    @(negedge clk);
    check("rst pre ack", {31'b0, ack[1]}, 32'h1);
    check("rst pre data", rdat[1], 32'h11111111);
    #1 rst_n = 1'b0;
    #1;
    check("rst ack", {31'b0, ack[1]}, 32'h0);
    check("rst dat", rdat[1], 32'h0);
    check("rst dat other", rdat[2], 32'h0);
    check("rst state", {30'b0, st[1]}, {30'b0, S_IDLE});
    cyc[1] = 1'b0; stb = 1'b0; cti = WB_CTI_CLASSIC;
    for (int d = 0; d < 3; d++) last_rd[d] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    classic(1, 0, 32'h3C, 32'h0, 4'hF, 32'h11111111, "post reset read");
    classic(1, 1, 32'h3C, 32'h0BADF00D, 4'h1, 32'h0, "post reset write");
    classic(1, 0, 32'h3C, 32'h0, 4'hF, 32'h1111110D, "post reset readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_sram.md
WB_BURST_SRAM -- requirements
Module: wb_burst_sram

Interface
REQ-001 Parameter adr_width, default 11, word-address bits; array depth 2^adr_width 32-bit words.
REQ-002 Parameter wait_states, default 1, range 0..7, extra cycles inserted before the first ack of each transfer.
REQ-003 sys_clk  in  1  sole clock, all state on rising edge.
REQ-004 sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 wb_adr_i  in  32  byte address; only bits [adr_width+1:2] used.
REQ-006 wb_dat_i  in  32  write data.
REQ-007 wb_dat_o  out  32  read data, registered.
REQ-008 wb_sel_i  in  4  byte lanes; bit n enables byte [8n+7:8n].
REQ-009 wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst; other codes are treated as 000.
REQ-010 wb_we_i  in  1  1 write, 0 read.
REQ-011 wb_cyc_i  in  1  cycle valid.
REQ-012 wb_stb_i  in  1  strobe.
REQ-013 wb_ack_o  out  1  transfer acknowledge.

Function
REQ-014 States IDLE, WAIT, ACK, BURST; the state register resets to IDLE.
REQ-015 IDLE: when cyc&stb is sampled, load the wait counter with wait_states and capture the word address; go to WAIT if wait_states>0, else ACK.
REQ-016 WAIT: decrement the counter each cycle; go to ACK when the counter reaches 1.
REQ-017 Latency: a request first sampled at edge T gets its ack in cycle T+1+wait_states.
REQ-018 wb_ack_o SHALL equal ack_r AND wb_cyc_i AND wb_stb_i, so ack is never asserted without a live strobe.
REQ-019 Read: wb_dat_o holds mem[addr] during the ack cycle, and holds its last value at all other times.
REQ-020 Write: only the bytes selected by wb_sel_i are committed, at the edge that ends the ack cycle.
REQ-021 Classic or end-of-burst beat: after ACK, return to IDLE; ack is low for at least one cycle, so no back-to-back classic acks occur.
REQ-022 ACK with cti=010 (burst build): go to BURST; ack stays high each cycle while cyc&stb&(cti==010).
REQ-023 BURST: the internal address increments by one word per acked beat, wrapping modulo 2^adr_width.
REQ-024 BURST: the next read word is prefetched so each beat returns the correct sequential data with zero wait states.
REQ-025 BURST: a beat with cti=111 is acked, then the block returns to IDLE.
REQ-026 If stb or cyc falls in WAIT or BURST: return to IDLE next cycle, perform no write for the unacked beat, and leave memory unchanged.
REQ-027 wb_adr_i upper bits are ignored; address decoding belongs to the interconnect.

Reset
REQ-028 On sys_rst_n low, asynchronously: wb_ack_o=0, ack_r=0, wb_dat_o=32'h0, state=IDLE, wait counter=0, address register=0.
REQ-029 Memory contents are not reset; a reset mid-transfer aborts it with no write.

Configuration
REQ-030 Macro WB_BURST_SRAM_BURST_EN.
REQ-031 With the macro defined: behaviour per REQ-022..025.
REQ-032 Without the macro: the BURST state is not built, cti is ignored, and every beat is classic with the full wait_states latency plus one idle cycle.

Structure
REQ-033 Shared package wb_pkg holds the CTI codes (WB_CTI_CLASSIC=3'b000, WB_CTI_INCR=3'b010, WB_CTI_EOB=3'b111) and the state encoding constants.
REQ-034 One sub-module, wb_sram_bank: a single-port byte-enabled synchronous RAM (adr_width, 32-bit, 4 byte-enables, 1-cycle read).

Verification
REQ-035 wait_states=1; write 32'hDEADBEEF to 0x40 with sel=4'hF, then read 0x40 -> ack 2 cycles after stb, wb_dat_o=32'hDEADBEEF.
REQ-036 Preload 0x40=32'h11223344; write 32'hAABBCCDD with sel=4'b0101; read back -> 32'h11BB33DD.
REQ-037 BURST_EN, wait_states=0; 4-beat read at 0x100 (cti 010,010,010,111), words 1..4 preloaded -> first ack at T+1, then 4 consecutive ack cycles returning 1,2,3,4, then ack low.
REQ-038 adr_width=4; burst read from word 15 -> second beat returns word 0.
REQ-039 wait_states=3; drop stb in WAIT during a write to 0x8 -> no ack, mem[0x8] unchanged, state IDLE.
REQ-040 Assert sys_rst_n=0 mid-burst -> ack low immediately, wb_dat_o=0, and the next classic read completes normally.
